// File: rtl/rs_station_if.sv
// Reservation station bus: dispatch bundle, two result broadcasts and the ALU issue port.
interface rs_station_if #(
  parameter int NICK_W = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 32
);
  logic              iROB_clr;
  logic              iDP_en;
  logic              iDP_rs_sel;
  logic [OP_W-1:0]   iDP_op;
  logic [ADDR_W-1:0] iDP_pc;
  logic [IMM_W-1:0]  iDP_imm;
  logic [NICK_W-1:0] iDP_rd_nick;
  logic [NICK_W-1:0] iDP_rs1_nick;
  logic [NICK_W-1:0] iDP_rs2_nick;
  logic [DATA_W-1:0] iDP_rs1_dt;
  logic [DATA_W-1:0] iDP_rs2_dt;
  logic              iALU_cdb_en;
  logic [NICK_W-1:0] iALU_cdb_nick;
  logic [DATA_W-1:0] iALU_cdb_dt;
  logic              iLSB_cdb_en;
  logic [NICK_W-1:0] iLSB_cdb_nick;
  logic [DATA_W-1:0] iLSB_cdb_dt;
  logic              oRS_full;
  logic              oALU_en;
  logic [OP_W-1:0]   oALU_op;
  logic [ADDR_W-1:0] oALU_pc;
  logic [IMM_W-1:0]  oALU_imm;
  logic [DATA_W-1:0] oALU_rs1_dt;
  logic [DATA_W-1:0] oALU_rs2_dt;
  logic [NICK_W-1:0] oALU_rd_nick;

  modport master (
    output iROB_clr, iDP_en, iDP_rs_sel, iDP_op, iDP_pc, iDP_imm, iDP_rd_nick,
           iDP_rs1_nick, iDP_rs2_nick, iDP_rs1_dt, iDP_rs2_dt,
           iALU_cdb_en, iALU_cdb_nick, iALU_cdb_dt,
           iLSB_cdb_en, iLSB_cdb_nick, iLSB_cdb_dt,
    input  oRS_full, oALU_en, oALU_op, oALU_pc, oALU_imm,
           oALU_rs1_dt, oALU_rs2_dt, oALU_rd_nick
  );

  modport slave (
    input  iROB_clr, iDP_en, iDP_rs_sel, iDP_op, iDP_pc, iDP_imm, iDP_rd_nick,
           iDP_rs1_nick, iDP_rs2_nick, iDP_rs1_dt, iDP_rs2_dt,
           iALU_cdb_en, iALU_cdb_nick, iALU_cdb_dt,
           iLSB_cdb_en, iLSB_cdb_nick, iLSB_cdb_dt,
    output oRS_full, oALU_en, oALU_op, oALU_pc, oALU_imm,
           oALU_rs1_dt, oALU_rs2_dt, oALU_rd_nick
  );
endinterface

// File: rtl/rs_station.sv
// ALU/branch reservation station: holds dispatched instructions, snoops the two
// result buses for missing operands and issues the lowest-index ready entry each cycle.
module rs_station #(
  parameter int DEPTH  = 8,
  parameter int NICK_W = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 32
) (
  input logic         clk,
  input logic         rst,
  input logic         rdy,
  rs_station_if.slave rsBus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [OP_W-1:0]   r_op     [DEPTH];
  logic [ADDR_W-1:0] r_pc     [DEPTH];
  logic [IMM_W-1:0]  r_imm    [DEPTH];
  logic [NICK_W-1:0] r_rdNick [DEPTH];
  logic [NICK_W-1:0] r_q1     [DEPTH];
  logic [NICK_W-1:0] r_q2     [DEPTH];
  logic [DATA_W-1:0] r_v1     [DEPTH];
  logic [DATA_W-1:0] r_v2     [DEPTH];

  logic              r_aluEn;
  logic [OP_W-1:0]   r_aluOp;
  logic [ADDR_W-1:0] r_aluPc;
  logic [IMM_W-1:0]  r_aluImm;
  logic [DATA_W-1:0] r_aluRs1;
  logic [DATA_W-1:0] r_aluRs2;
  logic [NICK_W-1:0] r_aluRd;

  logic              w_full;
  logic              w_alloc;
  logic              w_hasReady;
  logic [IDX_W-1:0]  w_freeIdx;
  logic [IDX_W-1:0]  w_readyIdx;
  logic [NICK_W-1:0] w_newQ1;
  logic [NICK_W-1:0] w_newQ2;
  logic [DATA_W-1:0] w_newV1;
  logic [DATA_W-1:0] w_newV2;

  assign w_full  = &r_valid;
  assign w_alloc = rsBus.iDP_en & rsBus.iDP_rs_sel & ~w_full;

  // Priority pick of the lowest free slot and the lowest ready slot from registered state
  always_comb begin
    w_freeIdx  = '0;
    w_readyIdx = '0;
    w_hasReady = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_freeIdx = IDX_W'(i);
      end
      if (r_valid[i] && r_q1[i] == '0 && r_q2[i] == '0) begin
        w_hasReady = 1'b1;
        w_readyIdx = IDX_W'(i);
      end
    end
  end

  // Catch a result broadcast in the same cycle the operand is dispatched; ALU bus wins ties
  always_comb begin
    w_newQ1 = rsBus.iDP_rs1_nick;
    w_newV1 = rsBus.iDP_rs1_dt;
    w_newQ2 = rsBus.iDP_rs2_nick;
    w_newV2 = rsBus.iDP_rs2_dt;
    if (rsBus.iDP_rs1_nick != '0) begin
      if (rsBus.iALU_cdb_en && rsBus.iALU_cdb_nick == rsBus.iDP_rs1_nick) begin
        w_newQ1 = '0;
        w_newV1 = rsBus.iALU_cdb_dt;
      end else if (rsBus.iLSB_cdb_en && rsBus.iLSB_cdb_nick == rsBus.iDP_rs1_nick) begin
        w_newQ1 = '0;
        w_newV1 = rsBus.iLSB_cdb_dt;
      end
    end
    if (rsBus.iDP_rs2_nick != '0) begin
      if (rsBus.iALU_cdb_en && rsBus.iALU_cdb_nick == rsBus.iDP_rs2_nick) begin
        w_newQ2 = '0;
        w_newV2 = rsBus.iALU_cdb_dt;
      end else if (rsBus.iLSB_cdb_en && rsBus.iLSB_cdb_nick == rsBus.iDP_rs2_nick) begin
        w_newQ2 = '0;
        w_newV2 = rsBus.iLSB_cdb_dt;
      end
    end
  end

  // Entry table and issue register: reset, freeze on !rdy, flush, then wakeup/issue/allocate
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_aluEn  <= 1'b0;
      r_aluOp  <= '0;
      r_aluPc  <= '0;
      r_aluImm <= '0;
      r_aluRs1 <= '0;
      r_aluRs2 <= '0;
      r_aluRd  <= '0;
    end else if (rdy) begin
      if (rsBus.iROB_clr) begin
        r_valid <= '0;
        r_aluEn <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_valid[i]) begin
            if (r_q1[i] != '0) begin
              if (rsBus.iALU_cdb_en && rsBus.iALU_cdb_nick == r_q1[i]) begin
                r_q1[i] <= '0;
                r_v1[i] <= rsBus.iALU_cdb_dt;
              end else if (rsBus.iLSB_cdb_en && rsBus.iLSB_cdb_nick == r_q1[i]) begin
                r_q1[i] <= '0;
                r_v1[i] <= rsBus.iLSB_cdb_dt;
              end
            end
            if (r_q2[i] != '0) begin
              if (rsBus.iALU_cdb_en && rsBus.iALU_cdb_nick == r_q2[i]) begin
                r_q2[i] <= '0;
                r_v2[i] <= rsBus.iALU_cdb_dt;
              end else if (rsBus.iLSB_cdb_en && rsBus.iLSB_cdb_nick == r_q2[i]) begin
                r_q2[i] <= '0;
                r_v2[i] <= rsBus.iLSB_cdb_dt;
              end
            end
          end
        end
        if (w_hasReady) begin
          r_valid[w_readyIdx] <= 1'b0;
          r_aluEn  <= 1'b1;
          r_aluOp  <= r_op[w_readyIdx];
          r_aluPc  <= r_pc[w_readyIdx];
          r_aluImm <= r_imm[w_readyIdx];
          r_aluRs1 <= r_v1[w_readyIdx];
          r_aluRs2 <= r_v2[w_readyIdx];
          r_aluRd  <= r_rdNick[w_readyIdx];
        end else begin
          r_aluEn <= 1'b0;
        end
        if (w_alloc) begin
          r_valid[w_freeIdx]  <= 1'b1;
          r_op[w_freeIdx]     <= rsBus.iDP_op;
          r_pc[w_freeIdx]     <= rsBus.iDP_pc;
          r_imm[w_freeIdx]    <= rsBus.iDP_imm;
          r_rdNick[w_freeIdx] <= rsBus.iDP_rd_nick;
          r_q1[w_freeIdx]     <= w_newQ1;
          r_v1[w_freeIdx]     <= w_newV1;
          r_q2[w_freeIdx]     <= w_newQ2;
          r_v2[w_freeIdx]     <= w_newV2;
        end
      end
    end
  end

  assign rsBus.oRS_full     = w_full;
  assign rsBus.oALU_en      = r_aluEn;
  assign rsBus.oALU_op      = r_aluOp;
  assign rsBus.oALU_pc      = r_aluPc;
  assign rsBus.oALU_imm     = r_aluImm;
  assign rsBus.oALU_rs1_dt  = r_aluRs1;
  assign rsBus.oALU_rs2_dt  = r_aluRs2;
  assign rsBus.oALU_rd_nick = r_aluRd;
endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: dispatch, wakeup, forwarding, full/drop, flush and rdy hold.
module tb_rs_station;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;

  rs_station_if bus ();

  rs_station dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .rsBus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    bus.iROB_clr      = 1'b0;
    bus.iDP_en        = 1'b0;
    bus.iDP_rs_sel    = 1'b0;
    bus.iDP_op        = '0;
    bus.iDP_pc        = '0;
    bus.iDP_imm       = '0;
    bus.iDP_rd_nick   = '0;
    bus.iDP_rs1_nick  = '0;
    bus.iDP_rs2_nick  = '0;
    bus.iDP_rs1_dt    = '0;
    bus.iDP_rs2_dt    = '0;
    bus.iALU_cdb_en   = 1'b0;
    bus.iALU_cdb_nick = '0;
    bus.iALU_cdb_dt   = '0;
    bus.iLSB_cdb_en   = 1'b0;
    bus.iLSB_cdb_nick = '0;
    bus.iLSB_cdb_dt   = '0;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                               input logic [3:0] rd, input logic [3:0] n1, input logic [31:0] d1,
                               input logic [3:0] n2, input logic [31:0] d2);
    bus.iDP_en       = 1'b1;
    bus.iDP_rs_sel   = 1'b1;
    bus.iDP_op       = op;
    bus.iDP_pc       = pc;
    bus.iDP_imm      = imm;
    bus.iDP_rd_nick  = rd;
    bus.iDP_rs1_nick = n1;
    bus.iDP_rs1_dt   = d1;
    bus.iDP_rs2_nick = n2;
    bus.iDP_rs2_dt   = d2;
  endtask

  task automatic aluCdb(input logic [3:0] nick, input logic [31:0] dt);
    bus.iALU_cdb_en   = 1'b1;
    bus.iALU_cdb_nick = nick;
    bus.iALU_cdb_dt   = dt;
  endtask

  task automatic lsbCdb(input logic [3:0] nick, input logic [31:0] dt);
    bus.iLSB_cdb_en   = 1'b1;
    bus.iLSB_cdb_nick = nick;
    bus.iLSB_cdb_dt   = dt;
  endtask

  // Linear directed sequence; inputs change on falling edges, outputs checked on falling edges
  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    clearInputs();
    step();
    step();
    checkOutput("reset_en",   64'(bus.oALU_en), 64'd0);
    checkOutput("reset_full", 64'(bus.oRS_full), 64'd0);
    checkOutput("reset_op",   64'(bus.oALU_op), 64'd0);
    checkOutput("reset_rs1",  64'(bus.oALU_rs1_dt), 64'd0);
    checkOutput("reset_rd",   64'(bus.oALU_rd_nick), 64'd0);
    rst = 1'b0;

    // Ready ADDI-like op issues one cycle after dispatch
    applyStimulus(6'd3, 32'h100, 32'd4, 4'd5, 4'd0, 32'd7, 4'd0, 32'd0);
    step();
    clearInputs();
    checkOutput("addi_residency_en", 64'(bus.oALU_en), 64'd0);
    step();
    checkOutput("addi_en",  64'(bus.oALU_en), 64'd1);
    checkOutput("addi_rs1", 64'(bus.oALU_rs1_dt), 64'd7);
    checkOutput("addi_rd",  64'(bus.oALU_rd_nick), 64'd5);
    checkOutput("addi_op",  64'(bus.oALU_op), 64'd3);
    checkOutput("addi_imm", 64'(bus.oALU_imm), 64'd4);
    checkOutput("addi_pc",  64'(bus.oALU_pc), 64'h100);
    step();
    checkOutput("addi_pulse_en", 64'(bus.oALU_en), 64'd0);
    checkOutput("addi_hold_op",  64'(bus.oALU_op), 64'd3);

    // Operands woken by ALU bus then LSB bus on successive cycles
    applyStimulus(6'h10, 32'h104, 32'd0, 4'd6, 4'd2, 32'd0, 4'd3, 32'd0);
    step();
    clearInputs();
    aluCdb(4'd2, 32'h10);
    step();
    checkOutput("wake_a_en", 64'(bus.oALU_en), 64'd0);
    clearInputs();
    lsbCdb(4'd3, 32'h20);
    step();
    checkOutput("wake_b_en", 64'(bus.oALU_en), 64'd0);
    clearInputs();
    step();
    checkOutput("wake_en",  64'(bus.oALU_en), 64'd1);
    checkOutput("wake_rs1", 64'(bus.oALU_rs1_dt), 64'h10);
    checkOutput("wake_rs2", 64'(bus.oALU_rs2_dt), 64'h20);
    checkOutput("wake_rd",  64'(bus.oALU_rd_nick), 64'd6);
    step();

    // Write-time forwarding from a same-cycle ALU broadcast
    applyStimulus(6'd2, 32'h108, 32'd0, 4'd7, 4'd4, 32'h55, 4'd0, 32'd1);
    aluCdb(4'd4, 32'd9);
    step();
    clearInputs();
    checkOutput("fwd_residency_en", 64'(bus.oALU_en), 64'd0);
    step();
    checkOutput("fwd_en",  64'(bus.oALU_en), 64'd1);
    checkOutput("fwd_rs1", 64'(bus.oALU_rs1_dt), 64'd9);
    checkOutput("fwd_rs2", 64'(bus.oALU_rs2_dt), 64'd1);
    step();

    // Fill all eight entries waiting on nick 6
    for (int i = 0; i < 7; i++) begin
      applyStimulus(6'd1, 32'h200 + 32'(4 * i), 32'd0, 4'(i + 1), 4'd6, 32'd0, 4'd0, 32'd0);
      step();
    end
    checkOutput("fill7_full", 64'(bus.oRS_full), 64'd0);
    applyStimulus(6'd1, 32'h21c, 32'd0, 4'd8, 4'd6, 32'd0, 4'd0, 32'd0);
    step();
    checkOutput("fill8_full", 64'(bus.oRS_full), 64'd1);
    applyStimulus(6'd1, 32'h220, 32'd0, 4'd9, 4'd0, 32'h99, 4'd0, 32'd0);
    step();
    clearInputs();
    checkOutput("drop_full", 64'(bus.oRS_full), 64'd1);
    checkOutput("drop_en",   64'(bus.oALU_en), 64'd0);
    aluCdb(4'd6, 32'h66);
    step();
    clearInputs();
    checkOutput("fill_wake_en",   64'(bus.oALU_en), 64'd0);
    checkOutput("fill_wake_full", 64'(bus.oRS_full), 64'd1);
    step();
    checkOutput("fill_issue0_en",   64'(bus.oALU_en), 64'd1);
    checkOutput("fill_issue0_rd",   64'(bus.oALU_rd_nick), 64'd1);
    checkOutput("fill_issue0_rs1",  64'(bus.oALU_rs1_dt), 64'h66);
    checkOutput("fill_issue0_full", 64'(bus.oRS_full), 64'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      checkOutput("fill_issue_en", 64'(bus.oALU_en), 64'd1);
      checkOutput("fill_issue_rd", 64'(bus.oALU_rd_nick), 64'(i + 1));
    end
    step();
    checkOutput("fill_drained_en", 64'(bus.oALU_en), 64'd0);

    // Flush three pending entries together with a ready dispatch
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'd4, 32'h300, 32'd0, 4'(10 + i), 4'd8, 32'd0, 4'd0, 32'd0);
      step();
    end
    applyStimulus(6'd4, 32'h30c, 32'd0, 4'd13, 4'd0, 32'h13, 4'd0, 32'd0);
    bus.iROB_clr = 1'b1;
    step();
    clearInputs();
    checkOutput("flush_en",   64'(bus.oALU_en), 64'd0);
    checkOutput("flush_full", 64'(bus.oRS_full), 64'd0);
    aluCdb(4'd8, 32'h88);
    step();
    clearInputs();
    step();
    checkOutput("flush_late_en1", 64'(bus.oALU_en), 64'd0);
    step();
    checkOutput("flush_late_en2", 64'(bus.oALU_en), 64'd0);
    checkOutput("flush_hold_rd",  64'(bus.oALU_rd_nick), 64'd8);

    // Both operands wake in one cycle from different buses
    applyStimulus(6'd5, 32'h400, 32'd0, 4'd2, 4'd9, 32'd0, 4'd10, 32'd0);
    step();
    clearInputs();
    aluCdb(4'd9, 32'hA);
    lsbCdb(4'd10, 32'hB);
    step();
    clearInputs();
    checkOutput("dual_wake_en", 64'(bus.oALU_en), 64'd0);
    step();
    checkOutput("dual_en",  64'(bus.oALU_en), 64'd1);
    checkOutput("dual_rs1", 64'(bus.oALU_rs1_dt), 64'hA);
    checkOutput("dual_rs2", 64'(bus.oALU_rs2_dt), 64'hB);
    step();

    // ALU bus takes priority when both buses carry the dispatched nick
    applyStimulus(6'd6, 32'h500, 32'd0, 4'd4, 4'd11, 32'd3, 4'd0, 32'd0);
    aluCdb(4'd11, 32'd1);
    lsbCdb(4'd11, 32'd2);
    step();
    clearInputs();
    step();
    checkOutput("prio_en",  64'(bus.oALU_en), 64'd1);
    checkOutput("prio_rs1", 64'(bus.oALU_rs1_dt), 64'd1);
    step();

    // rdy low freezes a ready entry for three cycles
    applyStimulus(6'd7, 32'h600, 32'd0, 4'd14, 4'd0, 32'h77, 4'd0, 32'd0);
    step();
    clearInputs();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("hold_en", 64'(bus.oALU_en), 64'd0);
    end
    rdy = 1'b1;
    step();
    checkOutput("hold_release_en",  64'(bus.oALU_en), 64'd1);
    checkOutput("hold_release_rd",  64'(bus.oALU_rd_nick), 64'd14);
    checkOutput("hold_release_rs1", 64'(bus.oALU_rs1_dt), 64'h77);
    step();
    checkOutput("hold_after_en", 64'(bus.oALU_en), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
